// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 VGA timing constants, derived sync/region bounds and the vertical region encoding
package vga_pkg;
  localparam int CW = 10;
  localparam int H_ACTIVE = 640;
  localparam int H_FP = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP = 33;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END = HS_START + H_SYNC - 1;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END = VS_START + V_SYNC - 1;
  typedef enum logic [1:0] {
    REG_ACTIVE = 2'd0,
    REG_FRONT = 2'd1,
    REG_SYNC = 2'd2,
    REG_BACK = 2'd3
  } v_region_t;
endpackage

// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: pixel strobe + h/v counts in (master drives), syncs/video_on/pixel coords/ticks/v_region/range_err out (slave drives)
interface vga_sync_gen_if;
  import vga_pkg::*;
  logic pix_en;
  logic [CW-1:0] h_count;
  logic [CW-1:0] v_count;
  logic hsync;
  logic vsync;
  logic video_on;
  logic [CW-1:0] pixel_x;
  logic [CW-1:0] pixel_y;
  logic line_tick;
  logic frame_tick;
  logic [1:0] v_region;
  logic range_err;
  modport master (
    output pix_en, h_count, v_count,
    input hsync, vsync, video_on, pixel_x, pixel_y, line_tick, frame_tick, v_region, range_err
  );
  modport slave (
    input pix_en, h_count, v_count,
    output hsync, vsync, video_on, pixel_x, pixel_y, line_tick, frame_tick, v_region, range_err
  );
endinterface

// File: rtl/vga_range_decode.sv
// vga_range_decode: hit=1 when count lies in [LO,HI] (unsigned); in: count, out: hit
module vga_range_decode #(
  parameter int W = 10,
  parameter int LO = 0,
  parameter int HI = 0
) (
  input logic [W-1:0] count,
  output logic hit
);
  logic [W-1:0] d;
  assign d = count - W'(LO);
  assign hit = d <= W'(HI - LO);
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: registers sync/video/coordinate/tick/region/error outputs from h/v counts sampled on pix_en; ports clk, reset, bus (slave)
module vga_sync_gen
  import vga_pkg::*;
(
  input logic clk,
  input logic reset,
  vga_sync_gen_if.slave bus
);
  logic h_ok, v_ok, hs_hit, vs_hit, ha_hit, va_hit, vf_hit, ok, h_last, v_last;
  logic hsync_q, vsync_q, video_on_q, line_tick_q, frame_tick_q, range_err_q;
  logic [CW-1:0] pixel_x_q, pixel_y_q;
  v_region_t state_q, state_d;
  vga_range_decode #(.W(CW), .LO(0), .HI(H_TOTAL - 1)) u_h_ok (.count(bus.h_count), .hit(h_ok));
  vga_range_decode #(.W(CW), .LO(0), .HI(V_TOTAL - 1)) u_v_ok (.count(bus.v_count), .hit(v_ok));
  vga_range_decode #(.W(CW), .LO(HS_START), .HI(HS_END)) u_hs (.count(bus.h_count), .hit(hs_hit));
  vga_range_decode #(.W(CW), .LO(VS_START), .HI(VS_END)) u_vs (.count(bus.v_count), .hit(vs_hit));
  vga_range_decode #(.W(CW), .LO(0), .HI(H_ACTIVE - 1)) u_ha (.count(bus.h_count), .hit(ha_hit));
  vga_range_decode #(.W(CW), .LO(0), .HI(V_ACTIVE - 1)) u_va (.count(bus.v_count), .hit(va_hit));
  vga_range_decode #(.W(CW), .LO(V_ACTIVE), .HI(VS_START - 1)) u_vf (.count(bus.v_count), .hit(vf_hit));
  assign ok = h_ok && v_ok;
  assign h_last = bus.h_count == CW'(H_TOTAL - 1);
  assign v_last = bus.v_count == CW'(V_TOTAL - 1);
  always_ff @(posedge clk) state_q <= reset ? REG_ACTIVE : state_d;
  always_comb state_d = !bus.pix_en ? state_q : va_hit ? REG_ACTIVE : vf_hit ? REG_FRONT : vs_hit ? REG_SYNC : REG_BACK;
  always_comb bus.v_region = state_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      video_on_q <= 1'b0;
      pixel_x_q <= '0;
      pixel_y_q <= '0;
      line_tick_q <= 1'b0;
      frame_tick_q <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      line_tick_q <= bus.pix_en && ok && h_last;
      frame_tick_q <= bus.pix_en && ok && h_last && v_last;
      range_err_q <= range_err_q || (bus.pix_en && !ok);
      if (bus.pix_en) begin
        hsync_q <= !(ok && hs_hit);
        vsync_q <= !(ok && vs_hit);
        video_on_q <= ha_hit && va_hit;
        pixel_x_q <= (ha_hit && va_hit) ? bus.h_count : '0;
        pixel_y_q <= (ha_hit && va_hit) ? bus.v_count : '0;
      end
    end
  end
  assign bus.hsync = hsync_q;
  assign bus.vsync = vsync_q;
  assign bus.video_on = video_on_q;
  assign bus.pixel_x = pixel_x_q;
  assign bus.pixel_y = pixel_y_q;
  assign bus.line_tick = line_tick_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.range_err = range_err_q;
endmodule
